// File: rtl/id_token_scanner_pkg.sv
// -----------------------------------------------------------------------------
// lex_pkg
// Shared definitions for the identifier/token scanner:
//   - state_e : scanner FSM state encoding (3 bits)
//   - tok_e   : token type codes reported on tok_type (2 bits)
//   - ASCII bound constants used by the character classifier
// -----------------------------------------------------------------------------
package lex_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,  // no token in progress
        S_ALPHA = 3'd1,  // started with a letter, last char a letter
        S_ALNUM = 3'd2,  // started with a letter, last char a digit
        S_NUM   = 3'd3,  // digits only so far
        S_BAD   = 3'd4,  // started with a digit, then a letter appeared
        S_OVF   = 3'd5   // token longer than the length counter can hold
    } state_e;

    typedef enum logic [1:0] {
        TOK_NONE   = 2'd0,
        TOK_IDENT  = 2'd1,
        TOK_NUMBER = 2'd2,
        TOK_BAD    = 2'd3
    } tok_e;

    localparam logic [7:0] ASC_DIGIT_0    = 8'h30;
    localparam logic [7:0] ASC_DIGIT_9    = 8'h39;
    localparam logic [7:0] ASC_UPPER_A    = 8'h41;
    localparam logic [7:0] ASC_UPPER_Z    = 8'h5A;
    localparam logic [7:0] ASC_LOWER_A    = 8'h61;
    localparam logic [7:0] ASC_LOWER_Z    = 8'h7A;
    localparam logic [7:0] ASC_UNDERSCORE = 8'h5F;

endpackage

// File: rtl/id_token_scanner_char_class.sv
// -----------------------------------------------------------------------------
// char_class
// Combinational ASCII classifier for the token scanner.
// Parameters:
//   ALLOW_UNDERSCORE : 1 = '_' counts as a letter, 0 = '_' is a delimiter
// Ports:
//   char_i    in  [7:0]  ASCII character
//   is_letter out        A-Z, a-z (and '_' when enabled)
//   is_digit  out        0-9
// Anything that is neither letter nor digit is a delimiter.
// -----------------------------------------------------------------------------
module char_class
    import lex_pkg::*;
#(
    parameter int ALLOW_UNDERSCORE = 1
) (
    input  logic [7:0] char_i,
    output logic       is_letter,
    output logic       is_digit
);

    logic is_upper;
    logic is_lower;
    logic is_under;

    assign is_upper  = (char_i >= ASC_UPPER_A) && (char_i <= ASC_UPPER_Z);
    assign is_lower  = (char_i >= ASC_LOWER_A) && (char_i <= ASC_LOWER_Z);
    assign is_under  = (ALLOW_UNDERSCORE != 0) && (char_i == ASC_UNDERSCORE);
    assign is_letter = is_upper || is_lower || is_under;
    assign is_digit  = (char_i >= ASC_DIGIT_0) && (char_i <= ASC_DIGIT_9);

endmodule

// File: rtl/id_token_scanner.sv
// -----------------------------------------------------------------------------
// id_token_scanner
// Consumes one ASCII character per accepted cycle, segments the stream into
// tokens on delimiters and classifies each token (IDENT / NUMBER / MALFORMED),
// reporting its length and a length-overflow flag. Keeps the legacy `match`
// level: high while the current run is letters followed by trailing digits.
//
// Parameters:
//   LEN_W            : length counter width; longest legal token 2^LEN_W-1
//   ALLOW_UNDERSCORE : 1 = '_' is a letter, 0 = '_' is a delimiter
// Optional build macro:
//   TOKEN_STATS_EN   : adds tok_cnt / err_cnt token statistics outputs
// Ports:
//   clk        in            rising-edge clock
//   reset      in            asynchronous active-high reset
//   in_valid   in            char_i is consumed this cycle
//   char_i     in  [7:0]     ASCII character
//   match      out           state is ALNUM
//   tok_valid  out           one-cycle pulse: token ended on last delimiter
//   tok_type   out [1:0]     token type while tok_valid, else 0
//   tok_len    out [LEN_W-1:0] token length while tok_valid, else 0
//   tok_err    out           token overflowed the length counter
//   busy       out           a token is in progress
//   tok_cnt    out [15:0]    (TOKEN_STATS_EN) emitted token count, wraps
//   err_cnt    out [15:0]    (TOKEN_STATS_EN) emitted overflow tokens, wraps
// -----------------------------------------------------------------------------
module id_token_scanner
    import lex_pkg::*;
#(
    parameter int LEN_W            = 5,
    parameter int ALLOW_UNDERSCORE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       char_i,
    output logic             match,
    output logic             tok_valid,
    output logic [1:0]       tok_type,
    output logic [LEN_W-1:0] tok_len,
    output logic             tok_err,
    output logic             busy
`ifdef TOKEN_STATS_EN
    ,
    output logic [15:0]      tok_cnt,
    output logic [15:0]      err_cnt
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic is_letter;
    logic is_digit;
    logic is_word;

    char_class #(
        .ALLOW_UNDERSCORE(ALLOW_UNDERSCORE)
    ) u_char_class (
        .char_i   (char_i),
        .is_letter(is_letter),
        .is_digit (is_digit)
    );

    assign is_word = is_letter || is_digit;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    tok_e             type_q, type_d;   // type of the token seen so far
    logic             match_q, busy_q;
    logic             tok_valid_q, tok_valid_d;
    tok_e             tok_type_q, tok_type_d;
    logic [LEN_W-1:0] tok_len_q, tok_len_d;
    logic             tok_err_q, tok_err_d;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        type_d      = type_q;
        tok_valid_d = 1'b0;
        tok_type_d  = TOK_NONE;
        tok_len_d   = '0;
        tok_err_d   = 1'b0;

        if (in_valid) begin
            if (!is_word) begin
                // Delimiter: close any open token and return to IDLE.
                if (state_q != S_IDLE) begin
                    tok_valid_d = 1'b1;
                    tok_type_d  = type_q;
                    tok_len_d   = len_q;
                    tok_err_d   = (state_q == S_OVF);
                end
                state_d = S_IDLE;
                len_d   = '0;
                type_d  = TOK_NONE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_d = is_letter ? S_ALPHA : S_NUM;
                        type_d  = is_letter ? TOK_IDENT : TOK_NUMBER;
                    end
                    S_ALPHA, S_ALNUM: begin
                        state_d = is_letter ? S_ALPHA : S_ALNUM;
                        type_d  = TOK_IDENT;
                    end
                    S_NUM: begin
                        state_d = is_letter ? S_BAD : S_NUM;
                        type_d  = is_letter ? TOK_BAD : TOK_NUMBER;
                    end
                    S_BAD: begin
                        state_d = S_BAD;
                        type_d  = TOK_BAD;
                    end
                    default: begin
                        // OVF: the type is frozen until the delimiter.
                        state_d = S_OVF;
                    end
                endcase

                // Length loads on the first char and saturates at all ones.
                if (state_q == S_IDLE) begin
                    len_d = LEN_ONE;
                end else if (len_q != LEN_MAX) begin
                    len_d = len_q + 1'b1;
                end

                // One character past the maximum length diverts into OVF,
                // keeping the type classification made above.
                if ((state_q != S_IDLE) && (len_q == LEN_MAX)) begin
                    state_d = S_OVF;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            type_q      <= TOK_NONE;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_type_q  <= TOK_NONE;
            tok_len_q   <= '0;
            tok_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            type_q      <= type_d;
            match_q     <= (state_d == S_ALNUM);
            busy_q      <= (state_d != S_IDLE);
            tok_valid_q <= tok_valid_d;
            tok_type_q  <= tok_type_d;
            tok_len_q   <= tok_len_d;
            tok_err_q   <= tok_err_d;
        end
    end

    assign match     = match_q;
    assign busy      = busy_q;
    assign tok_valid = tok_valid_q;
    assign tok_type  = tok_type_q;
    assign tok_len   = tok_len_q;
    assign tok_err   = tok_err_q;

`ifdef TOKEN_STATS_EN
    logic [15:0] tok_cnt_q;
    logic [15:0] err_cnt_q;

    // Counters step on the same edge that raises tok_valid; they wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tok_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (tok_valid_d) begin
            tok_cnt_q <= tok_cnt_q + 16'd1;
            if (tok_err_d) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign tok_cnt = tok_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_id_token_scanner.sv
// -----------------------------------------------------------------------------
// tb_id_token_scanner
// Directed bench for id_token_scanner. Three instances share the input
// stream: default parameters, LEN_W = 3, and ALLOW_UNDERSCORE = 0.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. One line is printed per consumed character.
// -----------------------------------------------------------------------------
module tb_id_token_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] char_i;

    always #5 clk = ~clk;

    // default instance
    logic       m0, tv0, err0, busy0;
    logic [1:0] ty0;
    logic [4:0] len0;
    // LEN_W = 3 instance
    logic       m3, tv3, err3, busy3;
    logic [1:0] ty3;
    logic [2:0] len3;
    // ALLOW_UNDERSCORE = 0 instance
    logic       mn, tvn, errn, busyn;
    logic [1:0] tyn;
    logic [4:0] lenn;
`ifdef TOKEN_STATS_EN
    logic [15:0] tok_cnt0, err_cnt0, tok_cnt3, err_cnt3, tok_cntn, err_cntn;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    id_token_scanner u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char_i(char_i),
        .match(m0), .tok_valid(tv0), .tok_type(ty0), .tok_len(len0),
        .tok_err(err0), .busy(busy0)
`ifdef TOKEN_STATS_EN
        , .tok_cnt(tok_cnt0), .err_cnt(err_cnt0)
`endif
    );

    id_token_scanner #(.LEN_W(3)) u_len3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char_i(char_i),
        .match(m3), .tok_valid(tv3), .tok_type(ty3), .tok_len(len3),
        .tok_err(err3), .busy(busy3)
`ifdef TOKEN_STATS_EN
        , .tok_cnt(tok_cnt3), .err_cnt(err_cnt3)
`endif
    );

    id_token_scanner #(.ALLOW_UNDERSCORE(0)) u_nous (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char_i(char_i),
        .match(mn), .tok_valid(tvn), .tok_type(tyn), .tok_len(lenn),
        .tok_err(errn), .busy(busyn)
`ifdef TOKEN_STATS_EN
        , .tok_cnt(tok_cntn), .err_cnt(err_cntn)
`endif
    );

    // Present one character for one accepted cycle, then sample.
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        char_i   = c;
        @(posedge clk);
        #1;
        $display("char 0x%02h: match=%0b busy=%0b tok_valid=%0b type=%0d len=%0d err=%0b | len3: tv=%0b type=%0d len=%0d err=%0b | nous: tv=%0b len=%0d",
                 c, m0, busy0, tv0, ty0, len0, err0, tv3, ty3, len3, err3, tvn, lenn);
    endtask

    // One idle cycle (in_valid low), then sample.
    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        char_i   = 8'h41;   // a letter: must be ignored while in_valid is low
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        char_i   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({m0, tv0, ty0, len0, err0, busy0} !== 11'd0)
            $display("FAIL reset_dut got %h required 0", {m0, tv0, ty0, len0, err0, busy0});
        else pass_cnt++;
        total_cnt++;
        if ({m3, tv3, ty3, len3, err3, busy3, mn, tvn, tyn, lenn, errn, busyn} !== 20'd0)
            $display("FAIL reset_others got %h required 0",
                     {m3, tv3, ty3, len3, err3, busy3, mn, tvn, tyn, lenn, errn, busyn});
        else pass_cnt++;
`ifdef TOKEN_STATS_EN
        total_cnt++;
        if ({tok_cnt0, err_cnt0} !== 32'd0)
            $display("FAIL reset_stats got %h required 0", {tok_cnt0, err_cnt0});
        else pass_cnt++;
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    // "ab12;" : match 0,0,1,1,0 then IDENT len 4
    task automatic test_ab12();
        string s = "ab12;";
        bit exp_m[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send(s[i]);
            total_cnt++;
            if (m0 !== exp_m[i]) $display("FAIL ab12_match[%0d] got %0b required %0b", i, m0, exp_m[i]);
            else pass_cnt++;
            if (i < 4) begin
                total_cnt++;
                if ({tv0, ty0, len0, err0, busy0} !== {9'd0, 1'b1})
                    $display("FAIL ab12_midtoken[%0d] got %h required 1", i, {tv0, ty0, len0, err0, busy0});
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({tv0, ty0, len0, err0, busy0} !== {1'b1, 2'd1, 5'd4, 1'b0, 1'b0})
            $display("FAIL ab12_token got %h required %h", {tv0, ty0, len0, err0, busy0},
                     {1'b1, 2'd1, 5'd4, 1'b0, 1'b0});
        else pass_cnt++;
        idle_cycle();
        total_cnt++;
        if ({tv0, ty0, len0, err0} !== 9'd0)
            $display("FAIL ab12_after got %h required 0", {tv0, ty0, len0, err0});
        else pass_cnt++;
    endtask

    // "a1" stall 3 cycles "b2 " : match holds, one IDENT len 4
    task automatic test_stall();
        send("a");
        send("1");
        total_cnt++;
        if (m0 !== 1'b1) $display("FAIL stall_match_pre got %0b required 1", m0);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            total_cnt++;
            if ({m0, busy0, tv0} !== 3'b110)
                $display("FAIL stall_hold[%0d] got %b required 110", k, {m0, busy0, tv0});
            else pass_cnt++;
        end
        send("b");
        total_cnt++;
        if ({m0, tv0} !== 2'b00) $display("FAIL stall_b got %b required 00", {m0, tv0});
        else pass_cnt++;
        send("2");
        send(" ");
        total_cnt++;
        if ({tv0, ty0, len0, err0} !== {1'b1, 2'd1, 5'd4, 1'b0})
            $display("FAIL stall_token got %h required %h", {tv0, ty0, len0, err0}, {1'b1, 2'd1, 5'd4, 1'b0});
        else pass_cnt++;
        idle_cycle();
        total_cnt++;
        if (tv0 !== 1'b0) $display("FAIL stall_single_pulse got %0b required 0", tv0);
        else pass_cnt++;
    endtask

    // "123;;9x," : NUMBER 3, nothing, MALFORMED 2; match stays 0
    task automatic test_num_bad();
        string s = "123;;9x,";
        logic [1:0] exp_ty[8]  = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3};
        logic [4:0] exp_len[8] = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd2};
        for (int i = 0; i < 8; i++) begin
            send(s[i]);
            total_cnt++;
            if ({m0, tv0, ty0, len0, err0} !== {1'b0, exp_ty[i] != 2'd0, exp_ty[i], exp_len[i], 1'b0})
                $display("FAIL numbad[%0d] got %h required %h", i, {m0, tv0, ty0, len0, err0},
                         {1'b0, exp_ty[i] != 2'd0, exp_ty[i], exp_len[i], 1'b0});
            else pass_cnt++;
        end
        idle_cycle();
    endtask

    // LEN_W = 3: OVF behaviour and the length boundary
    task automatic test_overflow();
        string s1 = "abcdefghi;";
        string s2 = "123456789 ";
        string s3 = "abcdefg;";
        string s4 = "abcdefg1;";
        for (int i = 0; i < 10; i++) begin
            send(s1[i]);
            if (i < 9) begin
                total_cnt++;
                if ({tv3, busy3} !== 2'b01) $display("FAIL ovf_mid[%0d] got %b required 01", i, {tv3, busy3});
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({tv3, ty3, len3, err3} !== {1'b1, 2'd1, 3'd7, 1'b1})
            $display("FAIL ovf_ident got %h required %h", {tv3, ty3, len3, err3}, {1'b1, 2'd1, 3'd7, 1'b1});
        else pass_cnt++;
        total_cnt++;
        if ({tv0, ty0, len0, err0} !== {1'b1, 2'd1, 5'd9, 1'b0})
            $display("FAIL ovf_wide_ident got %h required %h", {tv0, ty0, len0, err0}, {1'b1, 2'd1, 5'd9, 1'b0});
        else pass_cnt++;
`ifdef TOKEN_STATS_EN
        total_cnt++;
        if ({tok_cnt3, err_cnt3} !== {16'd5, 16'd1})
            $display("FAIL ovf_stats got %h required %h", {tok_cnt3, err_cnt3}, {16'd5, 16'd1});
        else pass_cnt++;
`endif
        for (int i = 0; i < 10; i++) send(s2[i]);
        total_cnt++;
        if ({tv3, ty3, len3, err3} !== {1'b1, 2'd2, 3'd7, 1'b1})
            $display("FAIL ovf_number got %h required %h", {tv3, ty3, len3, err3}, {1'b1, 2'd2, 3'd7, 1'b1});
        else pass_cnt++;
        for (int i = 0; i < 8; i++) send(s3[i]);
        total_cnt++;
        if ({tv3, ty3, len3, err3} !== {1'b1, 2'd1, 3'd7, 1'b0})
            $display("FAIL ovf_exact_max got %h required %h", {tv3, ty3, len3, err3}, {1'b1, 2'd1, 3'd7, 1'b0});
        else pass_cnt++;
        for (int i = 0; i < 9; i++) begin
            send(s4[i]);
            if (i == 7) begin
                // 8th char is a digit: wide instance is ALNUM, narrow one is OVF
                total_cnt++;
                if ({m0, m3, busy3} !== 3'b101)
                    $display("FAIL ovf_match got %b required 101", {m0, m3, busy3});
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({tv3, ty3, len3, err3, tv0, len0} !== {1'b1, 2'd1, 3'd7, 1'b1, 1'b1, 5'd8})
            $display("FAIL ovf_alnum got %h required %h", {tv3, ty3, len3, err3, tv0, len0},
                     {1'b1, 2'd1, 3'd7, 1'b1, 1'b1, 5'd8});
        else pass_cnt++;
`ifdef TOKEN_STATS_EN
        total_cnt++;
        if (err_cnt3 !== 16'd3) $display("FAIL ovf_errcnt got %0d required 3", err_cnt3);
        else pass_cnt++;
`endif
        idle_cycle();
    endtask

    // "a_b;" : with '_' a delimiter two IDENT len 1, otherwise one IDENT len 3
    task automatic test_underscore();
        string s = "a_b;";
        logic       exp_tvn[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0] exp_lenn[4] = '{5'd0, 5'd1, 5'd0, 5'd1};
        logic       exp_tv0[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0] exp_len0[4] = '{5'd0, 5'd0, 5'd0, 5'd3};
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            total_cnt++;
            if ({tvn, tyn, lenn} !== {exp_tvn[i], exp_tvn[i] ? 2'd1 : 2'd0, exp_lenn[i]})
                $display("FAIL us_off[%0d] got %h required %h", i, {tvn, tyn, lenn},
                         {exp_tvn[i], exp_tvn[i] ? 2'd1 : 2'd0, exp_lenn[i]});
            else pass_cnt++;
            total_cnt++;
            if ({tv0, ty0, len0} !== {exp_tv0[i], exp_tv0[i] ? 2'd1 : 2'd0, exp_len0[i]})
                $display("FAIL us_on[%0d] got %h required %h", i, {tv0, ty0, len0},
                         {exp_tv0[i], exp_tv0[i] ? 2'd1 : 2'd0, exp_len0[i]});
            else pass_cnt++;
        end
        idle_cycle();
    endtask

    // "ab", async reset between edges, then "7 " -> NUMBER len 1
    task automatic test_async_reset();
        send("a");
        send("b");
        total_cnt++;
        if ({busy0, tv0} !== 2'b10) $display("FAIL areset_pre got %b required 10", {busy0, tv0});
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({m0, tv0, ty0, len0, err0, busy0, busy3, busyn} !== 13'd0)
            $display("FAIL areset_async got %h required 0", {m0, tv0, ty0, len0, err0, busy0, busy3, busyn});
        else pass_cnt++;
        #1 reset = 1'b0;
        send("7");
        total_cnt++;
        if ({tv0, busy0, m0} !== 3'b010) $display("FAIL areset_7 got %b required 010", {tv0, busy0, m0});
        else pass_cnt++;
        send(" ");
        total_cnt++;
        if ({tv0, ty0, len0, err0} !== {1'b1, 2'd2, 5'd1, 1'b0})
            $display("FAIL areset_token got %h required %h", {tv0, ty0, len0, err0}, {1'b1, 2'd2, 5'd1, 1'b0});
        else pass_cnt++;
`ifdef TOKEN_STATS_EN
        total_cnt++;
        if ({tok_cnt0, err_cnt0} !== {16'd1, 16'd0})
            $display("FAIL areset_stats got %h required %h", {tok_cnt0, err_cnt0}, {16'd1, 16'd0});
        else pass_cnt++;
`endif
        idle_cycle();
        total_cnt++;
        if ({tv0, busy0} !== 2'b00) $display("FAIL areset_after got %b required 00", {tv0, busy0});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ab12();
        test_stall();
        test_num_bad();
        test_overflow();
        test_underscore();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
